// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard controller: FSM encoding, register
// indices and mul/div defaults.
package pipe_pkg;

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MD_BUSY  = 2'd2;

    localparam int unsigned REG_IDX_W      = 5;
    localparam logic [4:0]  REG_X0         = 5'd0;
    localparam int unsigned MD_LATENCY_DEF = 4;
    localparam int unsigned CNT_W_DEF      = 32;
    localparam int unsigned MD_CNT_W       = 4;

    // Remaining freeze cycles after the mul/div start cycle, minus the release cycle.
    function automatic logic [MD_CNT_W-1:0] md_init(input int unsigned lat);
        return (lat >= 2) ? MD_CNT_W'(lat - 2) : '0;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard detection: load-use comparators plus memory and
// mul/div structural stall requests.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_md_start,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 load_use_c,
    output logic                 mem_stall_c,
    output logic                 md_stall_c
);

    localparam logic MD_MULTI = 1'(MD_LATENCY > 1);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit     = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit     = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use_c  = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);
    assign mem_stall_c = mem_req && !mem_ready;
    assign md_stall_c  = ex_md_start && MD_MULTI;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: decodes pipeline-register
// enables and flushes from hazards and a small freeze FSM, and counts stalls.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 ex_md_start,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 if_id_flush,
    output logic                 id_ex_write,
    output logic                 id_ex_flush,
    output logic                 ex_mem_write,
    output logic                 freeze,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam logic [MD_CNT_W-1:0] MD_INIT = md_init(MD_LATENCY);

    logic [1:0]          state;
    logic [1:0]          next_state;
    logic [MD_CNT_W-1:0] md_cnt;
    logic [MD_CNT_W-1:0] next_md_cnt;
    logic                md_pending;
    logic                next_md_pending;
    logic                hold;
    logic                load_use;
    logic                mem_stall;
    logic                md_stall;

    hazard_detect #(
        .MD_LATENCY (MD_LATENCY)
    ) u_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .ex_md_start (ex_md_start),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .load_use_c  (load_use),
        .mem_stall_c (mem_stall),
        .md_stall_c  (md_stall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            md_cnt     <= '0;
            md_pending <= 1'b0;
        end else begin
            state      <= next_state;
            md_cnt     <= next_md_cnt;
            md_pending <= next_md_pending;
        end
    end

    // Next state and the freeze request; hold=0 means apply branch/load-use rules.
    always_comb begin
        next_state      = state;
        next_md_cnt     = md_cnt;
        next_md_pending = md_pending;
        hold            = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    hold            = 1'b1;
                    next_state      = MEM_WAIT;
                    next_md_pending = md_stall;
                end else if (md_stall) begin
                    hold        = 1'b1;
                    next_state  = MD_BUSY;
                    next_md_cnt = MD_INIT;
                end
            end
            MEM_WAIT: begin
                if (!mem_ready) begin
                    hold = 1'b1;
                end else if (md_pending) begin
                    hold            = 1'b1;
                    next_state      = MD_BUSY;
                    next_md_cnt     = MD_INIT;
                    next_md_pending = 1'b0;
                end else begin
                    next_state = RUN;
                end
            end
            MD_BUSY: begin
                if (md_cnt != '0) begin
                    hold        = 1'b1;
                    next_md_cnt = md_cnt - MD_CNT_W'(1);
                end else if (mem_stall) begin
                    // Memory still busy when mul/div ends: keep the freeze unbroken.
                    hold            = 1'b1;
                    next_state      = MEM_WAIT;
                    next_md_pending = 1'b0;
                end else begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state      = RUN;
                next_md_cnt     = '0;
                next_md_pending = 1'b0;
            end
        endcase
    end

    // Pipeline-register controls; reset decodes as RUN with no hazard.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b1;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        freeze       = 1'b0;
        if (!reset) begin
            if (hold) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_write = 1'b0;
                freeze       = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule
